// File: rtl/uart_tx_fifo.sv
// UART transmitter with a built-in baud generator and a transmit FIFO.
// Words enter on a valid/ready handshake, wait in a power-of-two FIFO and
// leave LSB-first as start / data / optional parity / stop frames.
module uart_tx_fifo #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUDRATE  = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int DEPTH     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_BITS-1:0]     din,
  input  logic                     din_valid,
  output logic                     din_ready,
  output logic                     tx,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUDRATE;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int PTR_W        = $clog2(DEPTH);
  localparam int FCNT_W       = PTR_W + 1;

  localparam logic [CNT_W-1:0]  BAUD_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]        DATA_LAST  = 4'(DATA_BITS - 1);
  localparam logic [3:0]        STOP_LAST  = 4'(STOP_BITS - 1);
  localparam logic [FCNT_W-1:0] FULL_COUNT = FCNT_W'(DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  // Parity bit that makes the total ones count even, inverted for odd parity.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
    return (PARITY == 1) ? ~(^d) : (^d);
  endfunction

  // FIFO storage and pointers
  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0]    count_q, count_d;

  // Serialiser state
  logic [2:0]           state_q, state_d;
  logic [CNT_W-1:0]     baud_q, baud_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;

  logic                 wr_en_s;
  logic                 pop_s;
  logic                 baud_end_s;
  logic [DATA_BITS-1:0] head_s;

  // Ready is withheld while full and while reset is asserted.
  assign din_ready  = (count_q != FULL_COUNT) && !reset;
  assign wr_en_s    = din_valid && din_ready;
  assign head_s     = mem_q[rd_ptr_q];
  assign baud_end_s = (baud_q == BAUD_LAST);

  assign tx         = tx_q;
  assign fifo_count = count_q;
  assign busy       = (state_q != S_IDLE) || (count_q != {FCNT_W{1'b0}});

  // Frame sequencer: baud timing, bit counting and popping the next word.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    pop_s   = 1'b0;
    baud_d  = baud_end_s ? {CNT_W{1'b0}} : baud_q + CNT_W'(1);
    case (state_q)
      S_IDLE: begin
        baud_d = {CNT_W{1'b0}};
        tx_d   = 1'b1;
        if (count_q != {FCNT_W{1'b0}}) begin
          pop_s   = 1'b1;
          shift_d = head_s;
          par_d   = parity_bit(head_s);
          tx_d    = 1'b0;
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (baud_end_s) begin
          bit_d   = 4'd0;
          tx_d    = shift_q[0];
          state_d = S_DATA;
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        if (baud_end_s) begin
          if (bit_q == DATA_LAST) begin
            bit_d = 4'd0;
            if (PARITY != 0) begin
              tx_d    = par_q;
              state_d = S_PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = S_STOP;
            end
          end else begin
            // Next data bit sits at position 1 before this shift lands.
            shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
            tx_d    = shift_q[1];
            bit_d   = bit_q + 4'd1;
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_PARITY: begin
        if (baud_end_s) begin
          bit_d   = 4'd0;
          tx_d    = 1'b1;
          state_d = S_STOP;
        end else begin
          state_d = S_PARITY;
        end
      end
      S_STOP: begin
        if (baud_end_s) begin
          if (bit_q == STOP_LAST) begin
            bit_d = 4'd0;
            if (count_q != {FCNT_W{1'b0}}) begin
              // Chain straight into the next start bit, no idle gap.
              pop_s   = 1'b1;
              shift_d = head_s;
              par_d   = parity_bit(head_s);
              tx_d    = 1'b0;
              state_d = S_START;
            end else begin
              tx_d    = 1'b1;
              state_d = S_IDLE;
            end
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          state_d = S_STOP;
        end
      end
      default: begin
        baud_d  = {CNT_W{1'b0}};
        bit_d   = 4'd0;
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // FIFO pointer and occupancy update for push, pop or both.
  always_comb begin
    wr_ptr_d = wr_en_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_s   ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({wr_en_s, pop_s})
      2'b10:   count_d = count_q + FCNT_W'(1);
      2'b01:   count_d = count_q - FCNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage write; data memory needs no reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  // State registers with synchronous reset that also aborts a frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      baud_q   <= {CNT_W{1'b0}};
      bit_q    <= 4'd0;
      shift_q  <= {DATA_BITS{1'b0}};
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {FCNT_W{1'b0}};
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: five instances with different frame
// formats share one clock; a scoreboard queue holds accepted words and a
// frame decoder compares what appears on tx against it.
module tb_uart_tx_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] vld;
  logic [7:0] din_b;
  wire  [4:0] rdy, txl, bsy;
  wire  [4:0] cnt0, cnt1, cnt2, cnt4;
  wire  [2:0] cnt3;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [8:0] exp_q[$];

  // Cycle counter used to measure frame spacing.
  always @(posedge clk) cyc <= cyc + 1;

  // 8N1, depth 16
  uart_tx_fifo #(.CLK_FREQ(1000), .BAUDRATE(100), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .DEPTH(16)) u0 (
    .clk(clk), .reset(rst), .din(din_b), .din_valid(vld[0]), .din_ready(rdy[0]),
    .tx(txl[0]), .busy(bsy[0]), .fifo_count(cnt0));
  // 8E1
  uart_tx_fifo #(.CLK_FREQ(1000), .BAUDRATE(100), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .DEPTH(16)) u1 (
    .clk(clk), .reset(rst), .din(din_b), .din_valid(vld[1]), .din_ready(rdy[1]),
    .tx(txl[1]), .busy(bsy[1]), .fifo_count(cnt1));
  // 8O1
  uart_tx_fifo #(.CLK_FREQ(1000), .BAUDRATE(100), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .DEPTH(16)) u2 (
    .clk(clk), .reset(rst), .din(din_b), .din_valid(vld[2]), .din_ready(rdy[2]),
    .tx(txl[2]), .busy(bsy[2]), .fifo_count(cnt2));
  // 8N2, depth 4
  uart_tx_fifo #(.CLK_FREQ(1000), .BAUDRATE(100), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .DEPTH(4)) u3 (
    .clk(clk), .reset(rst), .din(din_b), .din_valid(vld[3]), .din_ready(rdy[3]),
    .tx(txl[3]), .busy(bsy[3]), .fifo_count(cnt3));
  // 7N1
  uart_tx_fifo #(.CLK_FREQ(1000), .BAUDRATE(100), .DATA_BITS(7), .PARITY(0), .STOP_BITS(1), .DEPTH(16)) u4 (
    .clk(clk), .reset(rst), .din(din_b[6:0]), .din_valid(vld[4]), .din_ready(rdy[4]),
    .tx(txl[4]), .busy(bsy[4]), .fifo_count(cnt4));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input int idx, input logic [7:0] d);
    int n = 0;
    din_b    = d;
    vld[idx] = 1'b1;
    while (rdy[idx] !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      check_eq("send_timeout", 32'd1, 32'd0);
    end else begin
      exp_q.push_back({1'b0, (idx == 4) ? (d & 8'h7f) : d});
    end
    @(negedge clk);
    vld[idx] = 1'b0;
  endtask

  // Decode one frame, sampling each bit at its middle (10 clk per bit).
  task automatic recv(input int idx, input int db, input int pm, input int sb,
                      output logic [8:0] data, output logic pbit, output logic stop_ok,
                      output logic start_ok, output logic blast, output int t_start,
                      output bit to);
    int n = 0;
    data = 9'h000; pbit = 1'b0; stop_ok = 1'b1; start_ok = 1'b0;
    blast = 1'b0; t_start = 0; to = 1'b0;
    while (txl[idx] !== 1'b0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      to = 1'b1;
      return;
    end
    t_start = cyc;
    repeat (5) @(negedge clk);
    start_ok = ~txl[idx];
    for (int k = 0; k < db; k++) begin
      repeat (10) @(negedge clk);
      data[k] = txl[idx];
    end
    if (pm != 0) begin
      repeat (10) @(negedge clk);
      pbit = txl[idx];
    end
    for (int k = 0; k < sb; k++) begin
      repeat (10) @(negedge clk);
      stop_ok = stop_ok & txl[idx];
    end
    repeat (4) @(negedge clk);
    blast = bsy[idx];
    @(negedge clk);
  endtask

  // Decode a frame and compare it against the scoreboard head.
  task automatic rx_check(input string tag, input int idx, input int db, input int pm,
                          input int sb, output int t_start, output logic pbit, output logic blast);
    logic [8:0] data, exp;
    logic stop_ok, start_ok;
    bit to;
    recv(idx, db, pm, sb, data, pbit, stop_ok, start_ok, blast, t_start, to);
    if (to) begin
      check_eq({tag, "_timeout"}, 32'd1, 32'd0);
    end else if (exp_q.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      exp = exp_q.pop_front();
      check_eq({tag, "_start"}, start_ok, 1'b1);
      check_eq({tag, "_data"}, data, exp);
      check_eq({tag, "_stop"}, stop_ok, 1'b1);
      if (pm != 0) check_eq({tag, "_par"}, pbit, (^exp[7:0]) ^ (pm == 1));
    end
  endtask

  // Hard stop if anything hangs.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   ts, prev;
    int   lows;
    logic pb, bl;
    logic [7:0] bytes [6];
    bytes = '{8'hA1, 8'h3C, 8'h5E, 8'h07, 8'hF0, 8'h96};
    rst = 1'b1; vld = 5'b0; din_b = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_tx", txl, 5'h1f);
    check_eq("rst_busy", bsy, 5'h00);
    check_eq("rst_cnt", cnt0, 5'd0);
    check_eq("rst_rdy_low", rdy, 5'h00);
    rst = 1'b0;
    #1;
    check_eq("rst_rdy_high", rdy, 5'h1f);
    @(negedge clk);

    // 1: 8N1 byte 0x31, one-cycle latency, 100-cycle frame
    send(0, 8'h31);
    check_eq("t1_tx_w", txl[0], 1'b1);
    check_eq("t1_cnt_w", cnt0, 5'd1);
    check_eq("t1_busy_w", bsy[0], 1'b1);
    @(negedge clk);
    check_eq("t1_tx_lat", txl[0], 1'b0);
    check_eq("t1_cnt_pop", cnt0, 5'd0);
    rx_check("t1", 0, 8, 0, 1, ts, pb, bl);
    check_eq("t1_busy_last", bl, 1'b1);
    check_eq("t1_busy_end", bsy[0], 1'b0);
    check_eq("t1_tx_idle", txl[0], 1'b1);

    // 2: 8E1 and 8O1 byte 0x31, 110-cycle frames
    send(1, 8'h31);
    rx_check("t2e", 1, 8, 2, 1, ts, pb, bl);
    check_eq("t2e_pbit", pb, 1'b1);
    check_eq("t2e_len", {bl, bsy[1]}, 2'b10);
    send(2, 8'h31);
    rx_check("t2o", 2, 8, 1, 1, ts, pb, bl);
    check_eq("t2o_pbit", pb, 1'b0);
    check_eq("t2o_len", {bl, bsy[2]}, 2'b10);

    // 3: depth 4, 8N2, six bytes streamed back to back
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          if (i == 5) begin
            check_eq("t3_full_cnt", cnt3, 3'd4);
            check_eq("t3_full_rdy", rdy[3], 1'b0);
          end
          send(3, bytes[i]);
        end
      end
      begin
        prev = 0;
        for (int i = 0; i < 6; i++) begin
          rx_check("t3", 3, 8, 0, 2, ts, pb, bl);
          if (i > 0) check_eq("t3_gap", ts - prev, 32'd110);
          prev = ts;
        end
        check_eq("t3_end", {bl, bsy[3]}, 2'b10);
      end
    join

    // 4: 7N1 byte 0x7F, 90-cycle frame
    send(4, 8'h7f);
    rx_check("t4", 4, 7, 0, 1, ts, pb, bl);
    check_eq("t4_len", {bl, bsy[4]}, 2'b10);

    // 5: reset in the middle of the second of three queued frames
    send(0, 8'h11);
    send(0, 8'h22);
    send(0, 8'h33);
    rx_check("t5", 0, 8, 0, 1, ts, pb, bl);
    repeat (35) @(negedge clk);
    check_eq("t5_mid", bsy[0], 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("t5_tx", txl[0], 1'b1);
    check_eq("t5_cnt", cnt0, 5'd0);
    check_eq("t5_busy", bsy[0], 1'b0);
    check_eq("t5_rdy", rdy[0], 1'b1);
    exp_q.delete();
    lows = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (txl[0] !== 1'b1) lows++;
    end
    check_eq("t5_quiet", lows, 32'd0);

    // 6: writes during reset are ignored
    rst = 1'b1; vld[0] = 1'b1; din_b = 8'hAA;
    repeat (3) @(negedge clk);
    check_eq("t6_cnt_rst", cnt0, 5'd0);
    check_eq("t6_tx_rst", txl[0], 1'b1);
    rst = 1'b0; vld[0] = 1'b0;
    @(negedge clk);
    check_eq("t6_cnt_after", cnt0, 5'd0);
    check_eq("t6_tx_after", txl[0], 1'b1);

    // Clean frame after the reset
    send(0, 8'h5A);
    rx_check("t5_new", 0, 8, 0, 1, ts, pb, bl);
    check_eq("t5_new_end", {bl, bsy[0]}, 2'b10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
